pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
Fetch-side controller for the unpipelined RISC-V core.
- Owns the PC register and sequences one instruction at a time through an instruction-memory request/grant/response handshake.
- Hands each instruction to execute and waits for retirement.
- Applies the branch-taken / jump redirect decided by the branch unit.
- Raises a trap on a misaligned next-PC.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
TRAP_VEC, 32'h0000_0100, PC loaded after a misalignment trap is acknowledged

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset; one clock; asynchronous, active-low
stall  in  1  suppresses a new imem request while in FETCH
imem_req  out  1  instruction fetch request
imem_addr  out  32  fetch address (= pc)
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  fetch data valid (no earlier than the cycle after gnt)
imem_rdata  in  32  fetched instruction
instr_valid  out  1  instr/instr_pc valid to execute
instr  out  32  captured instruction
instr_pc  out  32  address of instr
instr_ready  in  1  execute retires instr this cycle
redirect_valid  in  1  branch taken or jump; sampled only at retire
redirect_target  in  32  redirect PC
trap_valid  out  1  misaligned next-PC trap pending
trap_pc  out  32  offending next-PC value
trap_ack  in  1  trap accepted by trap handler logic
retire_count  out  32  retired-instruction counter

Behaviour:
- Reset (rst_n=0, asynchronous): state=FETCH, pc=RESET_PC, instr=0, instr_pc=0, trap_pc=0, retire_count=0. All 1-bit outputs 0. imem_addr=RESET_PC.
- imem_req is combinational from state and stall. It is high the first cycle after reset release unless stall=1.
- States: FETCH, WAIT, HOLD, TRAP.
- FETCH:
  - imem_req = ~stall.
  - imem_req & imem_gnt -> WAIT.
  - stall=1 -> remain in FETCH; gnt is ignored while req=0.
- WAIT:
  - imem_req=0.
  - On imem_rvalid: instr<=imem_rdata, instr_pc<=pc, go to HOLD.
  - instr_valid is registered and is high from the cycle after rvalid.
  - stall has no effect.
- HOLD:
  - instr_valid=1; instr and instr_pc held stable until instr_ready.
  - On instr_ready, retire:
    - retire_count +=1, modulo 2^32.
    - next = redirect_valid ? redirect_target : pc+4 (32-bit wrap, so 32'hFFFF_FFFC+4 = 0).
    - If next[1:0]==0: pc<=next, go to FETCH.
    - Otherwise: trap_pc<=next, go to TRAP; pc unchanged.
  - redirect_valid outside a retire cycle is ignored.
- TRAP:
  - trap_valid=1; imem_req=0; instr_valid=0.
  - On trap_ack: pc<=TRAP_VEC, trap_valid falls next cycle, go to FETCH.
- Minimum instruction period: gnt in the first FETCH cycle, rvalid one cycle later, instr_ready in the first HOLD cycle = 3 cycles per instruction.
- Back-to-back retire then fetch: imem_addr shows the new pc in the cycle after retire.
- Reset mid-operation: immediate return to reset values in any state. Instruction memory shares rst_n, so no pre-reset response survives reset.
- imem_rvalid in FETCH/HOLD/TRAP and imem_gnt outside FETCH are ignored; this is an assertion-checkable protocol violation.
- retire_count wraps 32'hFFFF_FFFF -> 0.

Decomposition:
- Shared package holds:
  - FSM state encoding (2-bit: FETCH=0, WAIT=1, HOLD=2, TRAP=3).
  - Default RESET_PC and TRAP_VEC constants.
  - INSTR_BYTES=4 increment constant.
  - The branch funct3 constants (BEQ..BGEU) used by the branch-decision unit.
- One combinational sub-module, pc_next_calc, computes next-PC selection (pc+4 vs redirect_target) and the misalignment flag. The FSM, registers and counter stay in pc_sequencer.

Test Plan:
- Reset release, gnt immediate, rvalid next cycle with rdata=32'h0000_0013, instr_ready next -> imem_addr=0, instr_valid one cycle with instr_pc=0, then imem_addr=4, retire_count=1.
- Retire with redirect_valid=1, target=32'h0000_0040 -> next imem_addr=32'h40. Redirect asserted during WAIT with no retire -> ignored, next imem_addr=pc+4.
- Retire with redirect_target=32'h0000_0042 -> trap_valid=1, trap_pc=32'h42, no imem_req. trap_ack -> next fetch at 32'h100.
- stall=1 for 5 cycles in FETCH -> imem_req=0 throughout. Release -> req on the next cycle with the unchanged address.
- pc=32'hFFFF_FFFC, retire without redirect -> next imem_addr=0. retire_count preset-driven to 32'hFFFF_FFFF wraps to 0.
- rst_n pulsed low mid-WAIT and mid-HOLD -> all outputs at reset values asynchronously. Fetch restarts at RESET_PC after release.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch-side PC sequencer: FSM encoding, default
// vectors, the PC increment and the branch funct3 codes.
package pc_sequencer_pkg;

  // FSM state encoding (2-bit)
  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_TRAP  = 2'd3;

  // Default reset and trap vectors
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VEC = 32'h0000_0100;

  // Sequential PC step: one 32-bit instruction
  localparam logic [31:0] INSTR_BYTES = 32'd4;

  // Branch funct3 codes used by the branch-decision unit
  localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
  localparam logic [2:0] FUNCT3_BNE  = 3'b001;
  localparam logic [2:0] FUNCT3_BLT  = 3'b100;
  localparam logic [2:0] FUNCT3_BGE  = 3'b101;
  localparam logic [2:0] FUNCT3_BLTU = 3'b110;
  localparam logic [2:0] FUNCT3_BGEU = 3'b111;

  // Branch condition evaluation shared with the branch-decision unit
  function automatic logic branch_taken(input logic [2:0]  funct3,
                                        input logic [31:0] rs1,
                                        input logic [31:0] rs2);
    case (funct3)
      FUNCT3_BEQ:  return rs1 == rs2;
      FUNCT3_BNE:  return rs1 != rs2;
      FUNCT3_BLT:  return $signed(rs1) <  $signed(rs2);
      FUNCT3_BGE:  return $signed(rs1) >= $signed(rs2);
      FUNCT3_BLTU: return rs1 <  rs2;
      FUNCT3_BGEU: return rs1 >= rs2;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC selection at retire: redirect target or sequential PC, plus the
// misalignment flag for the selected value.
module pc_next_calc
  import pc_sequencer_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  // 32-bit add wraps naturally, so 0xFFFF_FFFC steps to 0
  assign next_pc    = redirect_valid ? redirect_target : pc + INSTR_BYTES;
  assign misaligned = next_pc[1:0] != 2'b00;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-side controller for the unpipelined core: owns the PC, runs one
// instruction at a time through the imem handshake, hands it to execute,
// applies redirects at retire and traps on a misaligned next-PC.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] TRAP_VEC = DEFAULT_TRAP_VEC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        trap_valid,
  output logic [31:0] trap_pc,
  input  logic        trap_ack,
  output logic [31:0] retire_count
);

  logic [1:0]  state;
  logic [1:0]  state_next;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        next_misaligned;
  logic        fetch_fire;
  logic        capture;
  logic        retire;
  logic        trap_done;

  pc_next_calc u_pc_next_calc (
    .pc              (pc),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .next_pc         (next_pc),
    .misaligned      (next_misaligned)
  );

  // The request is gated by rst_n so it stays low while reset is held, even
  // though the state register already reads FETCH.
  assign imem_req   = rst_n && (state == ST_FETCH) && !stall;
  assign imem_addr  = pc;

  // Per-state events; gnt/rvalid/ack outside their state are ignored.
  assign fetch_fire = imem_req && imem_gnt;
  assign capture    = (state == ST_WAIT) && imem_rvalid;
  assign retire     = (state == ST_HOLD) && instr_ready;
  assign trap_done  = (state == ST_TRAP) && trap_ack;

  // Next-state decode
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch forms.
    state_next = state;
    case (state)
      ST_FETCH: if (fetch_fire) state_next = ST_WAIT;
      ST_WAIT:  if (capture)    state_next = ST_HOLD;
      ST_HOLD:  if (retire)     state_next = next_misaligned ? ST_TRAP : ST_FETCH;
      ST_TRAP:  if (trap_done)  state_next = ST_FETCH;
      default:                  state_next = ST_FETCH;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments in clocked blocks keep every register
    // sampling pre-edge values regardless of block ordering.
    if (!rst_n) state <= ST_FETCH;
    else        state <= state_next;
  end

  // PC: advances on an aligned retire, jumps to the trap vector on ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          pc <= RESET_PC;
    else if (retire && !next_misaligned) pc <= next_pc;
    else if (trap_done)                  pc <= TRAP_VEC;
  end

  // Instruction capture for execute; held stable until retire
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr    <= '0;
      instr_pc <= '0;
    end else if (capture) begin
      instr    <= imem_rdata;
      instr_pc <= pc;
    end
  end

  // instr_valid: set the cycle after rvalid, cleared after retire
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       instr_valid <= 1'b0;
    else if (capture) instr_valid <= 1'b1;
    else if (retire)  instr_valid <= 1'b0;
  end

  // Trap flag and offending next-PC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_valid <= 1'b0;
      trap_pc    <= '0;
    end else if (retire && next_misaligned) begin
      trap_valid <= 1'b1;
      trap_pc    <= next_pc;
    end else if (trap_done) begin
      trap_valid <= 1'b0;
    end
  end

  // Retired-instruction counter, wraps modulo 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      retire_count <= '0;
    else if (retire) retire_count <= retire_count + 32'd1;
  end

endmodule
